// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: decodes IF/ID (and ID/EX for load-use) and steers
// the PC load/select and the IF/ID, ID/EX stall/flush/bubble controls.
module fetch_sequencer #(
    parameter int BR_DELAY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IfIdInstr,
    input  logic [31:0] IdExInstr,
    input  logic        BranchValid,
    input  logic        BranchTaken,
    output logic        PcWrite,
    output logic [1:0]  PcSel,
    output logic        IfIdWrite,
    output logic        IfIdFlush,
    output logic        IdExBubble,
    output logic        LinkWrite,
    output logic        Busy
);
    localparam logic [3:0] BR_DLY = 4'(BR_DELAY);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;
    localparam logic [1:0] SEL_JR  = 2'b11;

    typedef enum logic [1:0] {RUN, BR_WAIT, LD_STALL, JAL_LINK} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [5:0] op, funct, ex_op;
    logic [4:0] rs, rt, ex_rt;
    logic       is_br, is_j, is_jal, is_jr, is_lu;

    assign op    = IfIdInstr[31:26];
    assign rs    = IfIdInstr[25:21];
    assign rt    = IfIdInstr[20:16];
    assign funct = IfIdInstr[5:0];
    assign ex_op = IdExInstr[31:26];
    assign ex_rt = IdExInstr[20:16];

    assign is_br  = (op == 6'b000001) || (op == 6'b000100) || (op == 6'b000101) ||
                    (((op == 6'b000110) || (op == 6'b000111)) && (rt == 5'd0));
    assign is_j   = (op == 6'b000010);
    assign is_jal = (op == 6'b000011);
    assign is_jr  = (op == 6'b000000) && (funct == 6'b001000);
    // A load into $zero never creates a real dependency.
    assign is_lu  = (ex_op == 6'b100011) && (ex_rt != 5'd0) &&
                    ((rs == ex_rt) || (rt == ex_rt));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        PcWrite    = 1'b1;
        PcSel      = SEL_SEQ;
        IfIdWrite  = 1'b1;
        IfIdFlush  = 1'b0;
        IdExBubble = 1'b0;
        LinkWrite  = 1'b0;
        Busy       = (state != RUN);

        case (state)
            RUN: begin
                if (is_lu) begin
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExBubble = 1'b1;
                    state_nxt  = LD_STALL;
                end else if (is_jr) begin
                    PcSel     = SEL_JR;
                    IfIdFlush = 1'b1;
                end else if (is_br) begin
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExBubble = 1'b1;
                    cnt_nxt    = BR_DLY;
                    state_nxt  = BR_WAIT;
                end else if (is_j) begin
                    PcSel     = SEL_J;
                    IfIdFlush = 1'b1;
                end else if (is_jal) begin
                    LinkWrite  = 1'b1;
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExBubble = 1'b1;
                    state_nxt  = JAL_LINK;
                end
            end
            BR_WAIT: begin
                PcWrite    = 1'b0;
                IfIdWrite  = 1'b0;
                IdExBubble = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (BranchValid) begin
                    PcWrite   = 1'b1;
                    state_nxt = RUN;
                    if (BranchTaken) begin
                        PcSel     = SEL_BR;
                        IfIdFlush = 1'b1;
                    end else begin
                        IfIdWrite = 1'b1;
                    end
                end
            end
            LD_STALL: state_nxt = RUN;
            JAL_LINK: begin
                PcSel      = SEL_J;
                IfIdFlush  = 1'b1;
                IdExBubble = 1'b1;
                state_nxt  = RUN;
            end
            default: state_nxt = RUN;
        endcase

        // Reset aborts whatever is in flight: no redirect, no link write.
        if (Reset) begin
            PcWrite    = 1'b0;
            PcSel      = SEL_SEQ;
            IfIdWrite  = 1'b0;
            IfIdFlush  = 1'b1;
            IdExBubble = 1'b1;
            LinkWrite  = 1'b0;
            Busy       = 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (BR_DELAY 1 and 3) checked every
// cycle against a pending-action model, plus directed literal checks.
module tb_fetch_sequencer;
    logic        Clk;
    logic        rst;
    logic [31:0] ifid, idex;
    logic        bv, bt;

    logic       pcw [2];
    logic [1:0] psel [2];
    logic       ifw [2];
    logic       flu [2];
    logic       bub [2];
    logic       lnk [2];
    logic       bsy [2];

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.BR_DELAY(1)) dut1 (
        .Clk(Clk), .Reset(rst), .IfIdInstr(ifid), .IdExInstr(idex),
        .BranchValid(bv), .BranchTaken(bt),
        .PcWrite(pcw[0]), .PcSel(psel[0]), .IfIdWrite(ifw[0]), .IfIdFlush(flu[0]),
        .IdExBubble(bub[0]), .LinkWrite(lnk[0]), .Busy(bsy[0]));

    fetch_sequencer #(.BR_DELAY(3)) dut3 (
        .Clk(Clk), .Reset(rst), .IfIdInstr(ifid), .IdExInstr(idex),
        .BranchValid(bv), .BranchTaken(bt),
        .PcWrite(pcw[1]), .PcSel(psel[1]), .IfIdWrite(ifw[1]), .IfIdFlush(flu[1]),
        .IdExBubble(bub[1]), .LinkWrite(lnk[1]), .Busy(bsy[1]));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Model: outstanding obligations rather than a state register.
    int dly [2] = '{1, 3};
    bit stall_due [2], jump_due [2], br_open [2];
    int br_left [2];
    bit n_stall [2], n_jump [2], n_br [2];
    int n_left [2];

    function automatic logic [31:0] mk_r(int rs_, int rt_, int fn);
        return (32'(rs_) << 21) | (32'(rt_) << 16) | (32'd3 << 11) | 32'(fn);
    endfunction
    function automatic logic [31:0] mk_i(int opc, int rs_, int rt_);
        return (32'(opc) << 26) | (32'(rs_) << 21) | (32'(rt_) << 16) | 32'h0010;
    endfunction

    // 0 seq, 1 load-use, 2 jr, 3 branch, 4 j, 5 jal
    function automatic int klass(logic [31:0] a, logic [31:0] x);
        int opc, rs_, rt_, xop, xrt;
        opc = int'(a >> 26);
        rs_ = int'((a >> 21) & 32'h1f);
        rt_ = int'((a >> 16) & 32'h1f);
        xop = int'(x >> 26);
        xrt = int'((x >> 16) & 32'h1f);
        if (xop == 35 && xrt != 0 && (rs_ == xrt || rt_ == xrt)) return 1;
        if (opc == 0 && (a & 32'h3f) == 32'h08) return 2;
        if (opc == 1 || opc == 4 || opc == 5 || ((opc == 6 || opc == 7) && rt_ == 0)) return 3;
        if (opc == 2) return 4;
        if (opc == 3) return 5;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, req);
        end
    endtask

    function automatic logic [7:0] outs(int k);
        return {pcw[k], psel[k], ifw[k], flu[k], bub[k], lnk[k], bsy[k]};
    endfunction

    task automatic model_eval(input int k, output logic [7:0] e);
        bit w, ws, f, b, l, bz;
        logic [1:0] s;
        w = 1; s = 2'd0; ws = 1; f = 0; b = 0; l = 0; bz = 0;
        n_stall[k] = 0; n_jump[k] = 0; n_br[k] = br_open[k]; n_left[k] = br_left[k];
        if (rst) begin
            w = 0; ws = 0; f = 1; b = 1; n_br[k] = 0; n_left[k] = 0;
        end else if (stall_due[k]) begin
            bz = 1;
        end else if (jump_due[k]) begin
            bz = 1; s = 2'd2; f = 1; b = 1;
        end else if (br_open[k]) begin
            bz = 1; w = 0; ws = 0; b = 1;
            if (br_left[k] > 0) n_left[k] = br_left[k] - 1;
            else if (bv) begin
                n_br[k] = 0; w = 1;
                if (bt) begin s = 2'd1; f = 1; end
                else ws = 1;
            end
        end else begin
            case (klass(ifid, idex))
                1: begin w = 0; ws = 0; b = 1; n_stall[k] = 1; end
                2: begin s = 2'd3; f = 1; end
                3: begin w = 0; ws = 0; b = 1; n_br[k] = 1; n_left[k] = dly[k]; end
                4: begin s = 2'd2; f = 1; end
                5: begin l = 1; w = 0; ws = 0; b = 1; n_jump[k] = 1; end
                default: ;
            endcase
        end
        e = {w, s, ws, f, b, l, bz};
    endtask

    task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] x,
                       input logic v, input logic tk);
        logic [7:0] e;
        rst = r; ifid = a; idex = x; bv = v; bt = tk;
        #3;
        for (int k = 0; k < 2; k++) begin
            model_eval(k, e);
            chk(k == 0 ? "model_d1" : "model_d3", outs(k), e);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        for (int k = 0; k < 2; k++) begin
            stall_due[k] = n_stall[k]; jump_due[k] = n_jump[k];
            br_open[k] = n_br[k]; br_left[k] = n_left[k];
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        int r1, r2;
        r1 = int'($urandom_range(0, 15));
        r2 = int'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
            0, 1, 2: return mk_r(r1, r2, 32);
            3: return mk_i(35, r1, r2);
            4: return mk_i(int'($urandom_range(0, 2)) == 0 ? 1 : int'($urandom_range(4, 5)), r1, r2);
            5: return mk_i(int'($urandom_range(6, 7)), r1, ($urandom_range(0, 1) == 0) ? 0 : r2);
            6: return (32'd2 << 26) | 32'h10;
            7: return (32'd3 << 26) | 32'h10;
            8: return mk_r(r1, 0, 8);
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] ADD, BEQ, NOP, JAL, LW8, LW0, ADD8;

    initial begin
        ADD  = mk_r(1, 2, 32);
        ADD8 = mk_r(8, 9, 32);
        BEQ  = mk_i(4, 1, 2);
        NOP  = 32'h0;
        JAL  = (32'd3 << 26) | 32'h0000010;
        LW8  = mk_i(35, 29, 8);
        LW0  = mk_i(35, 29, 0);
        rst = 1; ifid = NOP; idex = NOP; bv = 0; bt = 0;
        @(posedge Clk); #1;

        // Reset cycle then sequential stream
        cyc(1, ADD, NOP, 0, 0);
        chk("rst_out", outs(0), 8'b0_00_0_1_1_0_0);
        tick();
        for (int i = 0; i < 3; i++) begin
            cyc(0, ADD, NOP, 0, 0);
            chk("seq", outs(0), 8'b1_00_1_0_0_0_0);
            tick();
        end

        // Load-use: one stall cycle, then resume
        cyc(0, ADD8, LW8, 0, 0);
        chk("lu_stall", outs(0), 8'b0_00_0_0_1_0_0);
        tick();
        cyc(0, ADD8, NOP, 0, 0);
        chk("lu_after", outs(0), 8'b1_00_1_0_0_0_1);
        tick();
        cyc(0, ADD, NOP, 0, 0);
        chk("lu_run", outs(0), 8'b1_00_1_0_0_0_0);
        tick();
        cyc(0, mk_r(0, 9, 32), LW0, 0, 0);
        chk("lu_rt0", outs(0), 8'b1_00_1_0_0_0_0);
        tick();

        // Branch taken / not taken with BR_DELAY=1
        for (int tk = 1; tk >= 0; tk--) begin
            cyc(0, BEQ, NOP, 0, 0);
            chk("br_c0", {7'd0, pcw[0]}, 8'd0);
            tick();
            cyc(0, BEQ, NOP, 1, tk[0]);
            chk("br_c1", {7'd0, pcw[0]}, 8'd0);
            tick();
            cyc(0, BEQ, NOP, 1, tk[0]);
            if (tk == 1) chk("br_tk", outs(0), 8'b1_01_0_1_1_0_1);
            else         chk("br_nt", outs(0), 8'b1_00_1_0_1_0_1);
            tick();
        end

        // BranchValid held low after counter expiry
        cyc(0, BEQ, NOP, 0, 0); tick();
        cyc(0, BEQ, NOP, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            cyc(0, BEQ, NOP, 0, 0);
            chk("br_hold", {pcw[0], 6'd0, bsy[0]}, 8'b0_000000_1);
            tick();
        end
        cyc(0, BEQ, NOP, 1, 1);
        chk("br_late", outs(0), 8'b1_01_0_1_1_0_1);
        tick();

        // JAL: link then redirect
        cyc(0, JAL, NOP, 0, 0);
        chk("jal_c0", outs(0), 8'b0_00_0_0_1_1_0);
        tick();
        cyc(0, NOP, NOP, 0, 0);
        chk("jal_c1", outs(0), 8'b1_10_1_1_1_0_1);
        tick();
        cyc(0, ADD, NOP, 0, 0);
        chk("jal_c2", {7'd0, lnk[0]}, 8'd0);
        tick();

        // Reset while dut3 waits with counter 3
        cyc(0, BEQ, NOP, 0, 0); tick();
        cyc(1, BEQ, NOP, 1, 1);
        chk("rst_brw", outs(1), 8'b0_00_0_1_1_0_0);
        tick();
        cyc(0, ADD, NOP, 1, 1);
        chk("rst_run", outs(1), 8'b1_00_1_0_0_0_0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 99) < 3), rnd_instr(),
                ($urandom_range(0, 1) == 0) ? mk_i(35, 29, int'($urandom_range(0, 15)))
                                            : mk_r(1, 2, 32),
                ($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
